// File: rtl/gpio_irq_wb8.sv
// Wishbone 8-bit GPIO with per-pin edge interrupts, banked in groups of 8 pins.
// Define GPIO_IRQ_ANYEDGE_EN to build the per-bank ANY register (both-edge interrupts).
module gpio_irq_wb8 #(
  parameter int unsigned NUM_PINS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                I_wb_clk,
  input  logic                I_reset,
  input  logic [4:0]          I_wb_adr,
  input  logic [7:0]          I_wb_dat,
  input  logic                I_wb_stb,
  input  logic                I_wb_we,
  output logic                O_wb_ack,
  output logic [7:0]          O_wb_dat,
  output logic                O_irq,
  inout  wire  [NUM_PINS-1:0] GPIO_port
);

  localparam int unsigned NBANKS = NUM_PINS / 8;

  typedef enum logic [2:0] {
    RegData, RegDir, RegSet, RegClr, RegIrqEn, RegEdge, RegStatus, RegAny
  } reg_e;

  logic                ack_q, irq_q;
  logic [7:0]          dat_q;
  logic [NUM_PINS-1:0] dir_q, dir_d, out_q, out_d, en_q, en_d, edge_q, edge_d;
  logic [NUM_PINS-1:0] pend_q, pend_d, prev_q;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
`ifdef GPIO_IRQ_ANYEDGE_EN
  logic [NUM_PINS-1:0] any_q, any_d;
`endif

  logic                access, wr;
  logic [1:0]          bank;
  reg_e                regi;
  logic [NUM_PINS-1:0] bmask, wr_vec, rd_vec, sync_v, rise, fall, sel, hit;
  logic [7:0]          rd_byte;

  assign sync_v = sync_q[SYNC_STAGES-1];

  always_comb begin
    access = I_wb_stb & ~ack_q;
    wr     = access & I_wb_we;
    bank   = I_wb_adr[1:0];
    regi   = reg_e'(I_wb_adr[4:2]);
    // Out-of-range banks leave the mask empty, so writes vanish and reads return 0
    bmask  = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      if (bank == 2'(b)) bmask[b*8 +: 8] = 8'hFF;
    end
    wr_vec = {NBANKS{I_wb_dat}} & bmask;

    rise = sync_v & ~prev_q;
    fall = ~sync_v & prev_q;
    sel  = (edge_q & rise) | (~edge_q & fall);
`ifdef GPIO_IRQ_ANYEDGE_EN
    sel  = (any_q & (rise | fall)) | (~any_q & sel);
`endif
    hit  = en_q & sel;

    dir_d  = dir_q;
    out_d  = out_q;
    en_d   = en_q;
    edge_d = edge_q;
    pend_d = pend_q;
`ifdef GPIO_IRQ_ANYEDGE_EN
    any_d  = any_q;
`endif
    if (wr) begin
      case (regi)
        RegData:   out_d  = (out_q & ~bmask) | wr_vec;
        RegDir:    dir_d  = (dir_q & ~bmask) | wr_vec;
        RegSet:    out_d  = out_q | wr_vec;
        RegClr:    out_d  = out_q & ~wr_vec;
        RegIrqEn:  en_d   = (en_q & ~bmask) | wr_vec;
        RegEdge:   edge_d = (edge_q & ~bmask) | wr_vec;
        RegStatus: pend_d = pend_q & ~wr_vec;
`ifdef GPIO_IRQ_ANYEDGE_EN
        RegAny:    any_d  = (any_q & ~bmask) | wr_vec;
`endif
        default:   ;
      endcase
    end
    // A new edge beats a simultaneous write-1-to-clear
    pend_d = pend_d | hit;

    rd_vec = '0;
    case (regi)
      RegData:          rd_vec = sync_v;
      RegDir:           rd_vec = dir_q;
      RegSet, RegClr:   rd_vec = out_q;
      RegIrqEn:         rd_vec = en_q;
      RegEdge:          rd_vec = edge_q;
      RegStatus:        rd_vec = pend_q;
`ifdef GPIO_IRQ_ANYEDGE_EN
      RegAny:           rd_vec = any_q;
`endif
      default:          rd_vec = '0;
    endcase
    rd_byte = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      if (bank == 2'(b)) rd_byte = rd_vec[b*8 +: 8];
    end
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
      dir_q  <= '0;
      out_q  <= '0;
      en_q   <= '0;
      edge_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
`ifdef GPIO_IRQ_ANYEDGE_EN
      any_q  <= '0;
`endif
    end else begin
      ack_q  <= I_wb_stb & ~ack_q;
      if (access && !I_wb_we) dat_q <= rd_byte;
      irq_q  <= |(pend_q & en_q);
      dir_q  <= dir_d;
      out_q  <= out_d;
      en_q   <= en_d;
      edge_q <= edge_d;
      pend_q <= pend_d;
      prev_q <= sync_v;
      sync_q[0] <= GPIO_port;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
`ifdef GPIO_IRQ_ANYEDGE_EN
      any_q  <= any_d;
`endif
    end
  end

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pad
    assign GPIO_port[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  assign O_wb_ack = ack_q;
  assign O_wb_dat = dat_q;
  assign O_irq    = irq_q;

endmodule

// File: tb/tb_gpio_irq_wb8.sv
// Scoreboard bench for gpio_irq_wb8: directed scenarios plus randomized bus/pin traffic
// checked against a per-bank byte model.
module tb_gpio_irq_wb8;

  localparam int S  = 2;
  localparam int NP = 16;
  localparam int NB = NP / 8;

  logic          clk = 1'b0;
  logic          rst, stb, we;
  logic [4:0]    adr;
  logic [7:0]    wdat;
  wire           ack, irq;
  wire  [7:0]    rdat;
  wire  [NP-1:0] pad;
  logic [NP-1:0] tb_en, tb_val;

  for (genvar i = 0; i < NP; i++) begin : g_drv
    assign pad[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  gpio_irq_wb8 #(.NUM_PINS(NP), .SYNC_STAGES(S)) dut (
    .I_wb_clk (clk),
    .I_reset  (rst),
    .I_wb_adr (adr),
    .I_wb_dat (wdat),
    .I_wb_stb (stb),
    .I_wb_we  (we),
    .O_wb_ack (ack),
    .O_wb_dat (rdat),
    .O_irq    (irq),
    .GPIO_port(pad)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_acks = 0;
  logic [8:0] sb[$];  // {is_read, expected data}

  // Behavioural model: one byte per bank and register, plus the bench's own pin drive
  logic [7:0] m_dir[4], m_out[4], m_en[4], m_edg[4], m_pend[4], m_in[4], m_any[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] pad_byte(input int b);
    return (m_dir[b] & m_out[b]) | (~m_dir[b] & m_in[b]);
  endfunction

  function automatic logic model_irq();
    logic r = 1'b0;
    for (int b = 0; b < NB; b++) r |= |(m_pend[b] & m_en[b]);
    return r;
  endfunction

  function automatic logic [7:0] model_read(input int b, input int r);
    if (b >= NB) return 8'h00;
    case (r)
      0: return pad_byte(b);
      1: return m_dir[b];
      2, 3: return m_out[b];
      4: return m_en[b];
      5: return m_edg[b];
      6: return m_pend[b];
`ifdef GPIO_IRQ_ANYEDGE_EN
      7: return m_any[b];
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edges(input int b, input logic [7:0] old_p, input logic [7:0] new_p);
    logic [7:0] rs, fl, hits;
    rs = new_p & ~old_p;
    fl = old_p & ~new_p;
    for (int i = 0; i < 8; i++) begin
      hits[i] = m_edg[b][i] ? rs[i] : fl[i];
`ifdef GPIO_IRQ_ANYEDGE_EN
      if (m_any[b][i]) hits[i] = rs[i] | fl[i];
`endif
    end
    m_pend[b] = m_pend[b] | (hits & m_en[b]);
  endtask

  task automatic drive_pins();
    for (int b = 0; b < NB; b++) begin
      tb_en[b*8 +: 8]  = ~m_dir[b];
      tb_val[b*8 +: 8] = m_in[b];
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_dir[b] = 0; m_out[b] = 0; m_en[b] = 0; m_edg[b] = 0; m_pend[b] = 0; m_any[b] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (S + 3) tick();
    check("irq_level", irq, model_irq());
  endtask

  // One bus access; model updates at the commit edge so pad drive tracks the DUT's DIR
  task automatic bus(input logic w, input int b, input int r, input logic [7:0] d);
    logic [7:0] old_p;
    stb = 1'b1; we = w; adr = {r[2:0], b[1:0]}; wdat = d;
    sb.push_back({~w, w ? 8'h00 : model_read(b, r)});
    @(posedge clk);
    if (w && b < NB) begin
      old_p = pad_byte(b);
      case (r)
        0: m_out[b] = d;
        1: m_dir[b] = d;
        2: m_out[b] = m_out[b] | d;
        3: m_out[b] = m_out[b] & ~d;
        4: m_en[b] = d;
        5: m_edg[b] = d;
        6: m_pend[b] = m_pend[b] & ~d;
`ifdef GPIO_IRQ_ANYEDGE_EN
        7: m_any[b] = d;
`endif
        default: ;
      endcase
      drive_pins();
      model_edges(b, old_p, pad_byte(b));
    end
    #1 stb = 1'b0;
    settle();
  endtask

  task automatic pin_set(input int b, input logic [7:0] v);
    logic [7:0] old_p;
    old_p = pad_byte(b);
    m_in[b] = v;
    drive_pins();
    model_edges(b, old_p, pad_byte(b));
    settle();
  endtask

  // Monitor: every ack pops one scoreboard entry; reads compare data
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (ack) begin
        n_acks++;
        if (sb.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          e = sb.pop_front();
          if (e[8]) check("read_data", rdat, e[7:0]);
        end
      end
    end
  end

  initial begin
    int n, a0;
    model_reset();
    for (int b = 0; b < 4; b++) m_in[b] = 0;
    drive_pins();
    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_ack", ack, 0);
    check("reset_dat", rdat, 0);
    check("reset_irq", irq, 0);
    for (int b = 0; b < 4; b++) begin
      bus(0, b, 1, 0); bus(0, b, 2, 0); bus(0, b, 4, 0); bus(0, b, 6, 0);
    end

    // Output latch and atomic set/clear on bank 1
    bus(1, 1, 1, 8'hFF); bus(1, 1, 0, 8'h0F); bus(1, 1, 2, 8'h30); bus(1, 1, 3, 8'h01);
    check("pins_15_8", pad[15:8], 8'h3E);
    bus(0, 1, 2, 0);
    bus(0, 1, 0, 0);

    // Held strobe: one access every two cycles
    a0 = n_acks;
    stb = 1'b1; we = 1'b0; adr = {3'd1, 2'd1};
    repeat (3) sb.push_back({1'b1, 8'hFF});
    repeat (6) tick();
    stb = 1'b0;
    repeat (2) tick();
    check("held_strobe_acks", n_acks - a0, 3);

    // Rising-edge interrupt latency on pin 0
    bus(1, 0, 4, 8'h01); bus(1, 0, 5, 8'h01);
    m_in[0] = 8'h01;
    drive_pins();
    model_edges(0, 8'h00, pad_byte(0));
    n = 0;
    while (!irq && n < 20) begin tick(); n++; end
    check("irq_latency", n, S + 2);
    bus(0, 0, 6, 0);
    bus(1, 0, 6, 8'h01);
    pin_set(0, 8'h00);
    bus(0, 0, 6, 0);

    // W1C in the same cycle as a new rising edge on pin 2
    bus(1, 0, 4, 8'h05); bus(1, 0, 5, 8'h05);
    m_in[0] = 8'h04;
    drive_pins();
    repeat (S) tick();
    stb = 1'b1; we = 1'b1; adr = {3'd6, 2'd0}; wdat = 8'h04;
    sb.push_back({1'b0, 8'h00});
    @(posedge clk);
    m_pend[0] = m_pend[0] & ~8'h04;
    model_edges(0, 8'h00, 8'h04);
    #1 stb = 1'b0;
    settle();
    bus(0, 0, 6, 0);
    check("race_pending2", m_pend[0][2], 1);

    // Any-edge register (reads 0 when not built)
    bus(1, 0, 7, 8'h02); bus(1, 0, 4, 8'h07); bus(1, 0, 6, 8'hFF);
    pin_set(0, 8'h06); bus(0, 0, 6, 0); bus(1, 0, 6, 8'hFF);
    pin_set(0, 8'h04); bus(0, 0, 6, 0); bus(0, 0, 7, 0);

    // Out-of-range banks
    bus(1, 3, 1, 8'hFF); bus(0, 3, 1, 0); bus(0, 2, 6, 0);

    // Randomized traffic
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(3, 0) == 0) pin_set($urandom_range(NB - 1, 0), 8'($urandom));
      else bus(1'($urandom), $urandom_range(3, 0), $urandom_range(7, 0), 8'($urandom));
    end

    // Reset asserted during a write strobe
    a0 = n_acks;
    stb = 1'b1; we = 1'b1; adr = {3'd1, 2'd0}; wdat = 8'hFF; rst = 1'b1;
    @(posedge clk);
    model_reset();
    drive_pins();
    #1 stb = 1'b0;
    tick();
    rst = 1'b0;
    check("reset_midaccess_ack", n_acks - a0, 0);
    settle();
    for (int b = 0; b < NB; b++) begin
      bus(0, b, 1, 0); bus(0, b, 2, 0); bus(0, b, 4, 0); bus(0, b, 5, 0); bus(0, b, 6, 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin tick(); n++; end
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
